ps2_piano_key_decoder: RTL and testbench
========================================

Name: ps2_piano_key_decoder

Overview:
- Consumes the PS/2 byte stream (`received_data` / `received_data_en`) from the PS/2 controller stage.
- Decodes scan-code set 2 make/break sequences for a 13-key, one-octave piano layout (A W S E D F T G Y H U J K = C4..C5).
- Maintains a held-key bitmap and emits single-cycle note-on/note-off events with typematic repeats suppressed.
- Provides a highest-held-note output for the downstream audio tone generator.

Parameters:
- NUM_KEYS, 13, number of mapped piano keys; indices 0..12 map to C4..C5 in ascending semitones.
- TIMEOUT_CYCLES, 2500000, CLOCK_50 cycles (50 ms) a prefix state may wait for its next byte before aborting to IDLE.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous active-low reset.
- received_data  input  8  byte from PS/2 controller; valid only when received_data_en=1.
- received_data_en  input  1  one-cycle strobe, one byte per strobe.
- key_down  output  13  held bitmap; bit i = key i currently pressed.
- note_valid  output  1  one-cycle event strobe.
- note_on  output  1  qualified by note_valid; 1 = press, 0 = release.
- note_index  output  4  qualified by note_valid; key index 0..12.
- active_valid  output  1  1 when any key_down bit is set.
- active_note  output  4  highest set index in key_down; 0 when active_valid=0.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, key_down=0, note_valid=0, note_on=0, note_index=0, timeout counter=0. active_valid/active_note follow key_down combinationally (→0/0).
- Scan map (hex → index): 1C→0, 1D→1, 1B→2, 24→3, 23→4, 2B→5, 2C→6, 34→7, 35→8, 33→9, 3C→10, 3B→11, 42→12. All other codes are unmapped.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen). Transitions occur only on received_data_en=1:
  - IDLE: F0→BRK; E0→EXT; mapped code→make event, stay IDLE; unmapped code→ignore, stay IDLE.
  - BRK: any byte→IDLE; a mapped byte produces a break event.
  - EXT: F0→EXT_BRK; any other byte→IDLE, no event (extended keys ignored).
  - EXT_BRK: any byte→IDLE, no event.
  - A second E0 or F0 arriving in BRK or EXT_BRK is consumed as the data byte (→IDLE, no event).
- Make event on key i:
  - If key_down[i]=0: set key_down[i]; note_valid=1, note_on=1, note_index=i.
  - If key_down[i]=1 (typematic repeat): no change, no pulse.
- Break event on key i:
  - If key_down[i]=1: clear key_down[i]; note_valid=1, note_on=0, note_index=i.
  - If key_down[i]=0: no pulse.
- Latency: key_down, note_valid, note_on and note_index are registered and update on the clock edge after the cycle in which received_data_en=1 (1 cycle). note_valid is high for exactly one cycle. note_on and note_index hold their values between events.
- active_note is a combinational priority encode (highest index wins) of registered key_down. It updates in the same cycle key_down changes.
- Timeout counter:
  - Cleared in IDLE and on every received_data_en.
  - Increments each cycle while in BRK, EXT or EXT_BRK.
  - On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE with no event.
  - If received_data_en coincides with the expiry cycle, the byte wins and is decoded in the current state.
- Controller power-up/BAT bytes (AA, FA, FC, EE, FE) are unmapped in IDLE and ignored.
- The pause sequence (E1 14 77 E1 F0 14 F0 77) produces no events.
- Reset mid-sequence (e.g. after F0) discards the prefix; the next mapped byte is treated as a make.
- No back-pressure: the block accepts every strobe; back-to-back strobes on consecutive cycles must be decoded correctly.

Test Plan:
- Reset, then bytes 1C, F0, 1C → pulse on=1 idx=0 one cycle after first strobe; pulse on=0 idx=0 after third strobe; key_down 0x0001→0x0000.
- Bytes 2B,2B,2B (typematic), then F0 2B → exactly one on pulse (idx=5) and one off pulse; key_down bit5 set then cleared.
- Press 1C (0), 33 (9), 1D (1) → active_note 0→9→9, active_valid=1; release 33 → active_note=1; release all → active_valid=0, active_note=0.
- Bytes E0 1C, E0 F0 1C, E0 75, F0 4A (unmapped break) → no note_valid pulses, key_down unchanged, FSM ends in IDLE.
- F0, then no byte for TIMEOUT_CYCLES (bench overrides to 100), then 1C → timeout returns FSM to IDLE; 1C decoded as make (on=1, idx=0), not break.
- Press 42 (idx 12), send F0, assert reset_n=0 asynchronously mid-cycle → key_down=0 and note_valid=0 immediately; after release, byte 42 yields on=1 idx=12.

Source files
------------

// File: rtl/ps2_piano_key_decoder.sv
// PS/2 scan-code set 2 decoder for a 13-key one-octave piano (C4..C5).
// Tracks held keys, emits note-on/off strobes with typematic repeats dropped, and reports the highest held note.
module ps2_piano_key_decoder #(
   parameter int NUM_KEYS       = 13,
   parameter int TIMEOUT_CYCLES = 2500000
) (
   input  logic                CLOCK_50,
   input  logic                reset_n,
   input  logic [7:0]          received_data,
   input  logic                received_data_en,
   output logic [NUM_KEYS-1:0] key_down,
   output logic                note_valid,
   output logic                note_on,
   output logic [3:0]          note_index,
   output logic                active_valid,
   output logic [3:0]          active_note
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BRK,
      S_EXT,
      S_EXT_BRK
   } state_t;

   state_t                r_state, w_state_next;
   logic [CNT_W-1:0]      r_cnt, w_cnt_next;
   logic [NUM_KEYS-1:0]   r_key_down;
   logic                  r_note_valid;
   logic                  r_note_on;
   logic [3:0]            r_note_index;

   logic                  w_hit;
   logic [3:0]            w_idx;
   logic                  w_ev_valid;
   logic                  w_ev_on;
   logic [3:0]            w_active_note;

   always_comb begin
      w_hit = 1'b1;
      w_idx = 4'd0;
      unique case (received_data)
         8'h1C: w_idx = 4'd0;
         8'h1D: w_idx = 4'd1;
         8'h1B: w_idx = 4'd2;
         8'h24: w_idx = 4'd3;
         8'h23: w_idx = 4'd4;
         8'h2B: w_idx = 4'd5;
         8'h2C: w_idx = 4'd6;
         8'h34: w_idx = 4'd7;
         8'h35: w_idx = 4'd8;
         8'h33: w_idx = 4'd9;
         8'h3C: w_idx = 4'd10;
         8'h3B: w_idx = 4'd11;
         8'h42: w_idx = 4'd12;
         default: w_hit = 1'b0;
      endcase
   end

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_ev_valid   = 1'b0;
      w_ev_on      = 1'b0;
      if (received_data_en) begin
         w_cnt_next = '0;
         unique case (r_state)
            S_IDLE: begin
               if (received_data == 8'hF0)
                  w_state_next = S_BRK;
               else if (received_data == 8'hE0)
                  w_state_next = S_EXT;
               else if (w_hit && !r_key_down[w_idx]) begin
                  w_ev_valid = 1'b1;
                  w_ev_on    = 1'b1;
               end
            end
            S_BRK: begin
               w_state_next = S_IDLE;
               if (w_hit && r_key_down[w_idx])
                  w_ev_valid = 1'b1;
            end
            S_EXT:     w_state_next = (received_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
            S_EXT_BRK: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
         endcase
      end else if (r_state == S_IDLE) begin
         w_cnt_next = '0;
      end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
         // A stalled prefix would otherwise turn the next press into a release.
         w_state_next = S_IDLE;
         w_cnt_next   = '0;
      end else begin
         w_cnt_next = r_cnt + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_key_down   <= '0;
         r_note_valid <= 1'b0;
         r_note_on    <= 1'b0;
         r_note_index <= 4'd0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_note_valid <= w_ev_valid;
         if (w_ev_valid) begin
            r_key_down[w_idx] <= w_ev_on;
            r_note_on         <= w_ev_on;
            r_note_index      <= w_idx;
         end
      end
   end

   always_comb begin
      w_active_note = 4'd0;
      for (int i = 0; i < NUM_KEYS; i++)
         if (r_key_down[i]) w_active_note = 4'(i);
   end

   assign key_down     = r_key_down;
   assign note_valid   = r_note_valid;
   assign note_on      = r_note_on;
   assign note_index   = r_note_index;
   assign active_valid = |r_key_down;
   assign active_note  = w_active_note;

endmodule

// File: tb/tb_ps2_piano_key_decoder.sv
// Scoreboard bench for ps2_piano_key_decoder: stimulus pushes expected note events, a monitor pops them on each strobe.
module tb_ps2_piano_key_decoder;

   localparam int NK = 13;
   localparam int TO = 100;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    rx_data;
   logic          rx_en;
   logic [NK-1:0] key_down;
   logic          note_valid;
   logic          note_on;
   logic [3:0]    note_index;
   logic          active_valid;
   logic [3:0]    active_note;

   typedef struct packed {
      logic       on;
      logic [3:0] idx;
   } ev_t;

   ev_t exp_q[$];
   int  n_pass  = 0;
   int  n_total = 0;
   bit  done    = 1'b0;

   always #10 clk = ~clk;

   ps2_piano_key_decoder #(.NUM_KEYS(NK), .TIMEOUT_CYCLES(TO)) dut (
      .CLOCK_50         (clk),
      .reset_n          (rst_n),
      .received_data    (rx_data),
      .received_data_en (rx_en),
      .key_down         (key_down),
      .note_valid       (note_valid),
      .note_on          (note_on),
      .note_index       (note_index),
      .active_valid     (active_valid),
      .active_note      (active_note)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Strobe lands at the next posedge; returns 1 time unit after it.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_en   = 1'b1;
      @(posedge clk);
      #1 rx_en = 1'b0;
   endtask

   task automatic press(input logic [7:0] b, input logic [3:0] idx);
      exp_q.push_back('{on: 1'b1, idx: idx});
      send(b);
   endtask

   task automatic release_key(input logic [7:0] b, input logic [3:0] idx);
      send(8'hF0);
      exp_q.push_back('{on: 1'b0, idx: idx});
      send(b);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every cycle note_valid is seen must match the oldest expected event.
   initial begin
      ev_t e;
      while (!done) begin
         @(negedge clk);
         if (note_valid && !done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", {27'd0, note_on, note_index}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("pulse_on",  {31'd0, note_on}, {31'd0, e.on});
               check("pulse_idx", {28'd0, note_index}, {28'd0, e.idx});
            end
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      rx_data = 8'h00;
      rx_en   = 1'b0;
      idle(3);
      check("rst_key_down",     32'(key_down), 32'h0);
      check("rst_note_valid",   {31'd0, note_valid}, 32'd0);
      check("rst_note_on",      {31'd0, note_on}, 32'd0);
      check("rst_note_index",   {28'd0, note_index}, 32'd0);
      check("rst_active_valid", {31'd0, active_valid}, 32'd0);
      check("rst_active_note",  {28'd0, active_note}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Basic make/break with one-cycle latency and one-cycle strobe.
      press(8'h1C, 4'd0);
      check("lat_valid_hi", {31'd0, note_valid}, 32'd1);
      check("kd_after_make", 32'(key_down), 32'h0001);
      idle(1);
      check("lat_valid_lo", {31'd0, note_valid}, 32'd0);
      release_key(8'h1C, 4'd0);
      check("kd_after_break", 32'(key_down), 32'h0000);
      idle(3);
      check("hold_note_on",    {31'd0, note_on}, 32'd0);
      check("hold_note_index", {28'd0, note_index}, 32'd0);

      // Typematic repeats, back-to-back strobes.
      press(8'h2B, 4'd5);
      send(8'h2B);
      send(8'h2B);
      check("kd_typematic", 32'(key_down), 32'h0020);
      release_key(8'h2B, 4'd5);
      check("kd_typematic_rel", 32'(key_down), 32'h0000);

      // Highest-held-note priority.
      press(8'h1C, 4'd0);
      check("act_0", {27'd0, active_valid, active_note}, {27'd0, 1'b1, 4'd0});
      press(8'h33, 4'd9);
      check("act_9", {27'd0, active_valid, active_note}, {27'd0, 1'b1, 4'd9});
      press(8'h1D, 4'd1);
      check("act_9b", {27'd0, active_valid, active_note}, {27'd0, 1'b1, 4'd9});
      release_key(8'h33, 4'd9);
      check("act_1", {27'd0, active_valid, active_note}, {27'd0, 1'b1, 4'd1});
      release_key(8'h1C, 4'd0);
      release_key(8'h1D, 4'd1);
      check("act_none", {27'd0, active_valid, active_note}, 32'd0);

      // Extended keys, unmapped breaks, BAT bytes, pause, doubled prefix: no events.
      press(8'h3C, 4'd10);
      send(8'hE0); send(8'h1C);
      send(8'hE0); send(8'hF0); send(8'h1C);
      send(8'hE0); send(8'hF0); send(8'h3C);
      send(8'hE0); send(8'h75);
      send(8'hF0); send(8'h4A);
      send(8'hAA); send(8'hFA); send(8'hFC); send(8'hEE); send(8'hFE);
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      send(8'hF0); send(8'hF0);
      check("kd_ext_unchanged", 32'(key_down), 32'h0400);
      press(8'h1C, 4'd0);
      check("kd_back_in_idle", 32'(key_down), 32'h0401);
      release_key(8'h1C, 4'd0);
      release_key(8'h3C, 4'd10);

      // Prefix survives a wait shorter than the timeout.
      press(8'h1D, 4'd1);
      send(8'hF0);
      idle(TO / 2);
      exp_q.push_back('{on: 1'b0, idx: 4'd1});
      send(8'h1D);
      check("kd_pre_timeout_break", 32'(key_down), 32'h0000);

      // Timeout aborts a stale F0, so 1C is a make.
      send(8'hF0);
      idle(TO + 20);
      press(8'h1C, 4'd0);
      check("kd_post_timeout_make", 32'(key_down), 32'h0001);
      release_key(8'h1C, 4'd0);

      // Asynchronous reset mid-sequence.
      press(8'h42, 4'd12);
      check("kd_42", 32'(key_down), 32'h1000);
      send(8'hF0);
      #4 rst_n = 1'b0;
      #1;
      check("async_rst_kd",    32'(key_down), 32'h0);
      check("async_rst_valid", {31'd0, note_valid}, 32'd0);
      check("async_rst_act",   {27'd0, active_valid, active_note}, 32'd0);
      idle(2);
      @(negedge clk) rst_n = 1'b1;
      press(8'h42, 4'd12);
      check("kd_after_rst_make", 32'(key_down), 32'h1000);
      idle(3);
      check("act_12", {27'd0, active_valid, active_note}, {27'd0, 1'b1, 4'd12});

      idle(4);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
